// File: rtl/ugemm_pkg.sv
// Shared types and helpers for the unary GEMM rate-coded PE row sequencer.
package ugemm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } ctrl_state_t;

  localparam int unsigned DEF_WIDTH  = 16;
  localparam int unsigned DEF_NUM_PE = 16;

  // Widest random number supported by bitrev.
  localparam int unsigned MAX_WIDTH = 32;
  localparam int unsigned IDX_W     = $clog2(MAX_WIDTH);

  // Reverses the low w bits of x (van der Corput order); upper bits read 0.
  function automatic logic [MAX_WIDTH-1:0] bitrev(input logic [MAX_WIDTH-1:0] x,
                                                   input int unsigned w);
    logic [MAX_WIDTH-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < MAX_WIDTH; i++) begin
      if (i < w) r[IDX_W'(i)] = x[IDX_W'(w - 1 - i)];
    end
    return r;
  endfunction

endpackage

// File: rtl/ugemm_rate_ctrl_valid_shift.sv
// Valid-tracking shift register: bit k follows the issue strobe delayed k+1 cycles.
module valid_shift #(
  parameter int unsigned NUM_PE = 16
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              shift_in,
  output logic [NUM_PE-1:0] vld
);

  if (NUM_PE == 1) begin : g_one
    always_ff @(posedge clk) begin
      if (clr) vld <= '0;
      else     vld <= shift_in;
    end
  end else begin : g_chain
    always_ff @(posedge clk) begin
      if (clr) vld <= '0;
      else     vld <= {vld[NUM_PE-2:0], shift_in};
    end
  end

endmodule

// File: rtl/ugemm_rate_ctrl.sv
// Per-job sequencer for a row of rate-coded unary multiplier PEs: issues the
// weight random pair for the stream length, drains the chain, pulses done.
module ugemm_rate_ctrl
  import ugemm_pkg::*;
#(
  parameter int unsigned WIDTH  = DEF_WIDTH,
  parameter int unsigned NUM_PE = DEF_NUM_PE,
  parameter int unsigned LEN_W  = WIDTH + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_start,
  input  logic [LEN_W-1:0]  i_len,
  output logic              o_ready,
  output logic              o_busy,
  output logic              o_issue,
  output logic [WIDTH-1:0]  o_randW,
  output logic [WIDTH-1:0]  o_randW_inv,
  output logic [NUM_PE-1:0] o_pe_valid,
  output logic              o_done
);

  localparam int unsigned       DCNT_W    = $clog2(NUM_PE) + 1;
  localparam logic [LEN_W-1:0]  LEN_CLAMP = LEN_W'(1) << WIDTH;
  localparam logic [DCNT_W-1:0] DCNT_LAST = DCNT_W'(NUM_PE - 1);

  ctrl_state_t       state_q, state_n;
  logic [LEN_W-1:0]  cnt_q, cnt_n;
  logic [LEN_W-1:0]  len_q, len_n;
  logic [DCNT_W-1:0] dcnt_q, dcnt_n;
  logic              issue_n;
  logic [WIDTH-1:0]  rev_n;
  logic [WIDTH-1:0]  randw_n;
  logic [WIDTH-1:0]  randw_inv_n;

  // State and counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      len_q   <= '0;
      dcnt_q  <= '0;
    end else begin
      state_q <= state_n;
      cnt_q   <= cnt_n;
      len_q   <= len_n;
      dcnt_q  <= dcnt_n;
    end
  end

  // Next-state, counters and next-cycle output values.
  always_comb begin
    state_n     = state_q;
    cnt_n       = cnt_q;
    len_n       = len_q;
    dcnt_n      = dcnt_q;
    issue_n     = 1'b0;
    rev_n       = '0;
    randw_n     = '0;
    randw_inv_n = '0;

    case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          // 0 and anything past 2^WIDTH both mean a full-length stream.
          len_n   = ((i_len == '0) || (i_len > LEN_CLAMP)) ? LEN_CLAMP : i_len;
          cnt_n   = '0;
          state_n = ST_RUN;
        end
      end
      ST_RUN: begin
        cnt_n = cnt_q + LEN_W'(1);
        if (cnt_q == len_q - LEN_W'(1)) begin
          dcnt_n  = '0;
          state_n = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        dcnt_n = dcnt_q + DCNT_W'(1);
        if (dcnt_q == DCNT_LAST) state_n = ST_DONE;
      end
      ST_DONE: begin
        state_n = ST_IDLE;
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase

    // Outputs are registered, so they are computed from the next state.
    issue_n = (state_n == ST_RUN);
    rev_n   = WIDTH'(bitrev(MAX_WIDTH'(cnt_n), WIDTH));
    if (issue_n) begin
      randw_n     = rev_n;
      randw_inv_n = ~rev_n;
    end
  end

  // Registered handshake and random-pair outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      o_ready     <= 1'b1;
      o_busy      <= 1'b0;
      o_issue     <= 1'b0;
      o_randW     <= '0;
      o_randW_inv <= '0;
      o_done      <= 1'b0;
    end else begin
      o_ready     <= (state_n == ST_IDLE);
      o_busy      <= (state_n != ST_IDLE);
      o_issue     <= issue_n;
      o_randW     <= randw_n;
      o_randW_inv <= randw_inv_n;
      o_done      <= (state_n == ST_DONE);
    end
  end

  valid_shift #(
    .NUM_PE (NUM_PE)
  ) u_valid_shift (
    .clk      (clk),
    .clr      (rst),
    .shift_in (o_issue),
    .vld      (o_pe_valid)
  );

endmodule

// File: tb/tb_ugemm_rate_ctrl.sv
// Directed bench for ugemm_rate_ctrl at WIDTH=4, NUM_PE=3.
module tb_ugemm_rate_ctrl;

  localparam int unsigned WIDTH  = 4;
  localparam int unsigned NUM_PE = 3;
  localparam int unsigned LEN_W  = WIDTH + 1;

  logic              clk;
  logic              rst;
  logic              i_start;
  logic [LEN_W-1:0]  i_len;
  logic              o_ready;
  logic              o_busy;
  logic              o_issue;
  logic [WIDTH-1:0]  o_randW;
  logic [WIDTH-1:0]  o_randW_inv;
  logic [NUM_PE-1:0] o_pe_valid;
  logic              o_done;

  int total;
  int bad;

  ugemm_rate_ctrl #(
    .WIDTH  (WIDTH),
    .NUM_PE (NUM_PE),
    .LEN_W  (LEN_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .i_start     (i_start),
    .i_len       (i_len),
    .o_ready     (o_ready),
    .o_busy      (o_busy),
    .o_issue     (o_issue),
    .o_randW     (o_randW),
    .o_randW_inv (o_randW_inv),
    .o_pe_valid  (o_pe_valid),
    .o_done      (o_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired before summary");
    $fatal(1, "watchdog");
  end

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; i_start = 1'b0; i_len = '0;
    repeat (3) tick();
    rst = 1'b0;
    total++; if (o_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", o_ready); end
    total++; if (o_busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", o_busy); end
    total++; if (o_issue !== 1'b0) begin bad++; $display("FAIL reset_issue got=%b exp=0", o_issue); end
    total++; if (o_done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", o_done); end
    total++; if (o_randW !== 4'd0) begin bad++; $display("FAIL reset_randW got=%0d exp=0", o_randW); end
    total++; if (o_randW_inv !== 4'd0) begin bad++; $display("FAIL reset_randW_inv got=%0d exp=0", o_randW_inv); end
    total++; if (o_pe_valid !== 3'b000) begin bad++; $display("FAIL reset_pe_valid got=%b exp=000", o_pe_valid); end
  endtask

  task automatic test_short_job();
    logic [3:0] w_tab [4];
    logic       e_issue, e_v2, e_v0, e_done, e_ready;
    logic [3:0] e_w, e_wi;
    w_tab = '{4'd0, 4'd8, 4'd4, 4'd12};
    i_len = 5'd4; i_start = 1'b1;
    tick();
    i_start = 1'b0;
    for (int n = 1; n <= 10; n++) begin
      e_issue = (n <= 4);
      if (n <= 4) begin e_w = w_tab[n-1]; e_wi = ~w_tab[n-1]; end
      else        begin e_w = 4'd0;       e_wi = 4'd0;        end
      e_v0    = (n >= 2) && (n <= 5);
      e_v2    = (n >= 4) && (n <= 7);
      e_done  = (n == 8);
      e_ready = (n >= 9);
      total++; if (o_issue !== e_issue) begin bad++; $display("FAIL short_issue n=%0d got=%b exp=%b", n, o_issue, e_issue); end
      total++; if (o_randW !== e_w) begin bad++; $display("FAIL short_randW n=%0d got=%0d exp=%0d", n, o_randW, e_w); end
      total++; if (o_randW_inv !== e_wi) begin bad++; $display("FAIL short_randW_inv n=%0d got=%0d exp=%0d", n, o_randW_inv, e_wi); end
      total++; if (o_pe_valid[0] !== e_v0) begin bad++; $display("FAIL short_valid0 n=%0d got=%b exp=%b", n, o_pe_valid[0], e_v0); end
      total++; if (o_pe_valid[2] !== e_v2) begin bad++; $display("FAIL short_valid2 n=%0d got=%b exp=%b", n, o_pe_valid[2], e_v2); end
      total++; if (o_done !== e_done) begin bad++; $display("FAIL short_done n=%0d got=%b exp=%b", n, o_done, e_done); end
      total++; if (o_ready !== e_ready) begin bad++; $display("FAIL short_ready n=%0d got=%b exp=%b", n, o_ready, e_ready); end
      total++; if (o_busy !== ~e_ready) begin bad++; $display("FAIL short_busy n=%0d got=%b exp=%b", n, o_busy, ~e_ready); end
      if (n < 10) tick();
    end
  endtask

  task automatic test_len_one();
    logic [2:0] e_v;
    i_len = 5'd1; i_start = 1'b1;
    tick();
    i_start = 1'b0;
    for (int n = 1; n <= 6; n++) begin
      e_v = ((n >= 2) && (n <= 4)) ? (3'b001 << (n - 2)) : 3'b000;
      total++; if (o_issue !== (n == 1)) begin bad++; $display("FAIL len1_issue n=%0d got=%b exp=%b", n, o_issue, (n == 1)); end
      total++; if (o_randW_inv !== ((n == 1) ? 4'd15 : 4'd0)) begin bad++; $display("FAIL len1_randW_inv n=%0d got=%0d", n, o_randW_inv); end
      total++; if (o_pe_valid !== e_v) begin bad++; $display("FAIL len1_pe_valid n=%0d got=%b exp=%b", n, o_pe_valid, e_v); end
      total++; if (o_done !== (n == 5)) begin bad++; $display("FAIL len1_done n=%0d got=%b exp=%b", n, o_done, (n == 5)); end
      if (n < 6) tick();
    end
    total++; if (o_ready !== 1'b1) begin bad++; $display("FAIL len1_ready got=%b exp=1", o_ready); end
  endtask

  task automatic test_len_clamp();
    logic [4:0]  lens [3];
    logic [15:0] seen;
    int          cnt, dup, n;
    logic        got_done;
    lens = '{5'd0, 5'd20, 5'd16};
    for (int j = 0; j < 3; j++) begin
      i_len = lens[j]; i_start = 1'b1;
      tick();
      i_start = 1'b0;
      seen = '0; cnt = 0; dup = 0; got_done = 1'b0; n = 1;
      while (!got_done && n <= 40) begin
        if (o_issue) begin
          if (seen[o_randW]) dup++;
          seen[o_randW] = 1'b1;
          cnt++;
        end
        if (o_done) got_done = 1'b1;
        else begin tick(); n++; end
      end
      total++; if (got_done !== 1'b1) begin bad++; $display("FAIL clamp_done_timeout len=%0d got=%b exp=1", lens[j], got_done); end
      total++; if (cnt != 16) begin bad++; $display("FAIL clamp_issue_count len=%0d got=%0d exp=16", lens[j], cnt); end
      total++; if (dup != 0) begin bad++; $display("FAIL clamp_dup len=%0d got=%0d exp=0", lens[j], dup); end
      total++; if (seen !== 16'hFFFF) begin bad++; $display("FAIL clamp_cover len=%0d got=%h exp=ffff", lens[j], seen); end
      total++; if (n != 20) begin bad++; $display("FAIL clamp_done_cycle len=%0d got=%0d exp=20", lens[j], n); end
      tick();
      total++; if (o_ready !== 1'b1) begin bad++; $display("FAIL clamp_ready len=%0d got=%b exp=1", lens[j], o_ready); end
    end
  endtask

  task automatic test_busy_start();
    int issues, dones, done_n;
    issues = 0; dones = 0; done_n = 0;
    i_len = 5'd5; i_start = 1'b1;
    tick();
    i_start = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      if (o_issue) issues++;
      if (o_done) begin dones++; done_n = n; end
      if (n == 5) begin
        total++; if (o_randW !== 4'd2) begin bad++; $display("FAIL busy_randW5 got=%0d exp=2", o_randW); end
      end
      if (n == 2) begin i_start = 1'b1; i_len = 5'd2; end
      if (n == 3) begin i_start = 1'b0; i_len = 5'd0; end
      if (n < 20) tick();
    end
    total++; if (issues != 5) begin bad++; $display("FAIL busy_issue_count got=%0d exp=5", issues); end
    total++; if (dones != 1) begin bad++; $display("FAIL busy_done_count got=%0d exp=1", dones); end
    total++; if (done_n != 9) begin bad++; $display("FAIL busy_done_cycle got=%0d exp=9", done_n); end
    total++; if (o_ready !== 1'b1) begin bad++; $display("FAIL busy_ready got=%b exp=1", o_ready); end
  endtask

  task automatic test_back_to_back();
    logic       e_issue, e_done, e_ready;
    logic [3:0] e_w;
    i_len = 5'd2; i_start = 1'b1;
    tick();
    for (int n = 1; n <= 15; n++) begin
      e_issue = (n == 1) || (n == 2) || (n == 8) || (n == 9);
      e_done  = (n == 6) || (n == 13);
      e_ready = (n == 7) || (n >= 14);
      e_w     = ((n == 2) || (n == 9)) ? 4'd8 : 4'd0;
      total++; if (o_issue !== e_issue) begin bad++; $display("FAIL b2b_issue n=%0d got=%b exp=%b", n, o_issue, e_issue); end
      total++; if (o_done !== e_done) begin bad++; $display("FAIL b2b_done n=%0d got=%b exp=%b", n, o_done, e_done); end
      total++; if (o_ready !== e_ready) begin bad++; $display("FAIL b2b_ready n=%0d got=%b exp=%b", n, o_ready, e_ready); end
      total++; if (o_randW !== e_w) begin bad++; $display("FAIL b2b_randW n=%0d got=%0d exp=%0d", n, o_randW, e_w); end
      if (n == 13) i_start = 1'b0;
      if (n < 15) tick();
    end
  endtask

  task automatic test_mid_reset();
    i_len = 5'd3; i_start = 1'b1;
    tick();
    i_start = 1'b0;
    repeat (4) tick();
    total++; if (o_pe_valid !== 3'b110) begin bad++; $display("FAIL midrst_pre_valid got=%b exp=110", o_pe_valid); end
    total++; if (o_busy !== 1'b1) begin bad++; $display("FAIL midrst_pre_busy got=%b exp=1", o_busy); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++; if (o_pe_valid !== 3'b000) begin bad++; $display("FAIL midrst_valid got=%b exp=000", o_pe_valid); end
    total++; if (o_ready !== 1'b1) begin bad++; $display("FAIL midrst_ready got=%b exp=1", o_ready); end
    total++; if (o_busy !== 1'b0) begin bad++; $display("FAIL midrst_busy got=%b exp=0", o_busy); end
    total++; if (o_issue !== 1'b0) begin bad++; $display("FAIL midrst_issue got=%b exp=0", o_issue); end
    for (int n = 0; n < 5; n++) begin
      tick();
      total++; if (o_done !== 1'b0) begin bad++; $display("FAIL midrst_done n=%0d got=%b exp=0", n, o_done); end
      total++; if (o_ready !== 1'b1) begin bad++; $display("FAIL midrst_idle n=%0d got=%b exp=1", n, o_ready); end
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst = 1'b1; i_start = 1'b0; i_len = '0;
    test_reset();
    test_short_job();
    test_len_one();
    test_len_clamp();
    test_busy_start();
    test_back_to_back();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
